// File: rtl/sigma_delta_decimator.sv
// Sigma-delta bitstream decimator: turns a 1-bit oversampled stream into one
// excess-2^MSBI PCM sample per window of 2^(MSBI+1) enabled samples.
// Build option: define SD_DECIM_SINC2_EN to replace the boxcar (sinc1)
// accumulator with a second-order CIC (sinc2) filter.
module sigma_delta_decimator #(
    parameter int   MSBI = 7,
    parameter logic INV  = 1'b1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          CE,
    input  logic          DSin,
    output logic          FBout,
    output logic [MSBI:0] DOUT,
    output logic          VALID,
    output logic          SAT
);

    localparam logic [MSBI:0]   MID  = {1'b1, {MSBI{1'b0}}};
    localparam logic [MSBI+1:0] FULL = {1'b1, {(MSBI + 1){1'b0}}};

    logic          r_s1;
    logic          r_s2;
    logic          w_b;
    logic [MSBI:0] r_phase;
    logic          w_phaseLast;
    logic [MSBI+1:0] w_result;
    logic          w_emit;

    assign FBout       = r_s2;
    assign w_b         = r_s2 ^ INV;
    assign w_phaseLast = (r_phase == '1);

    // Two-flop synchroniser for the asynchronous bitstream; runs regardless of CE
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= DSin;
            r_s2 <= r_s1;
        end
    end

    // Window position counter, advancing once per enabled sample and wrapping naturally
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_phase <= '0;
        end else if (CE) begin
            r_phase <= r_phase + 1'b1;
        end
    end

`ifdef SD_DECIM_SINC2_EN
    localparam int CW = 2 * (MSBI + 1) + 1;

    logic [CW-1:0] r_i1;
    logic [CW-1:0] r_i2;
    logic [CW-1:0] r_i2Prev;
    logic [CW-1:0] r_c1Prev;
    logic          r_primed;
    logic [CW-1:0] w_i2Next;
    logic [CW-1:0] w_c1;
    logic [CW-1:0] w_c2;

    // The comb stage sees the integrator value that includes the closing sample
    assign w_i2Next = r_i2 + r_i1;
    assign w_c1     = w_i2Next - r_i2Prev;
    assign w_c2     = w_c1 - r_c1Prev;
    assign w_result = (MSBI + 2)'(w_c2 >> (MSBI + 1));
    assign w_emit   = r_primed;

    // Two wrapping integrators plus the comb history captured at each window close
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_i1     <= '0;
            r_i2     <= '0;
            r_i2Prev <= '0;
            r_c1Prev <= '0;
            r_primed <= 1'b0;
        end else if (CE) begin
            r_i1 <= r_i1 + {{(CW - 1){1'b0}}, w_b};
            r_i2 <= w_i2Next;
            if (w_phaseLast) begin
                r_i2Prev <= w_i2Next;
                r_c1Prev <= w_c1;
                r_primed <= 1'b1;
            end
        end
    end
`else
    logic [MSBI+1:0] r_acc;

    assign w_result = r_acc + {{(MSBI + 1){1'b0}}, w_b};
    assign w_emit   = 1'b1;

    // Boxcar ones counter, cleared as the closing sample is folded into the result
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_acc <= '0;
        end else if (CE) begin
            if (w_phaseLast) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_result;
            end
        end
    end
`endif

    // Output register: publish the window result with a one-cycle strobe, clipping full scale
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            DOUT  <= MID;
            VALID <= 1'b0;
            SAT   <= 1'b0;
        end else begin
            VALID <= 1'b0;
            SAT   <= 1'b0;
            if (CE && w_phaseLast && w_emit) begin
                VALID <= 1'b1;
                if (w_result >= FULL) begin
                    DOUT <= '1;
                    SAT  <= 1'b1;
                end else begin
                    DOUT <= w_result[MSBI:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Directed testbench for sigma_delta_decimator. Two instances share stimulus:
// dut0 uses INV=0, dut1 uses the default INV=1. With SD_DECIM_SINC2_EN defined
// the sinc2 scenarios run instead of the sinc1 ones.
module tb_sigma_delta_decimator;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CE = 1'b0;
    logic       DSin = 1'b0;
    logic       f0, v0, s0;
    logic       f1, v1, s1;
    logic [7:0] d0, d1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int patDs = 0;
    int patCe = 0;
    bit ceOn = 0;
    int at;

    sigma_delta_decimator #(.MSBI(7), .INV(1'b0)) dut0 (
        .CLK(CLK), .RESET(RESET), .CE(CE), .DSin(DSin),
        .FBout(f0), .DOUT(d0), .VALID(v0), .SAT(s0)
    );

    sigma_delta_decimator #(.MSBI(7), .INV(1'b1)) dut1 (
        .CLK(CLK), .RESET(RESET), .CE(CE), .DSin(DSin),
        .FBout(f1), .DOUT(d1), .VALID(v1), .SAT(s1)
    );

    always #5 CLK = ~CLK;

    // DSin pattern by mode: const0, const1, toggle, 1-in-4, 3-in-4, step at 510
    function automatic logic patBit(input int mode, input int c);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (c % 2 == 1);
            3:       return (c % 4 == 0);
            4:       return (c % 4 != 0);
            default: return (c >= 510);
        endcase
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        DSin = patBit(patDs, cyc);
        CE   = ceOn ? ((patCe == 0) ? 1'b1 : (cyc % 4 == 0)) : 1'b0;
    endtask

    // Prefill the synchroniser with the pattern (CE low), then enable CE from cyc 0
    task automatic startPattern(input int ds, input int ce);
        patDs = ds;
        patCe = ce;
        ceOn  = 0;
        cyc   = 0;
        repeat (3) step();
        cyc  = 0;
        ceOn = 1;
        DSin = patBit(ds, 0);
        CE   = 1'b1;
    endtask

    task automatic waitValid(input int sel, input int budget, output int atCyc);
        atCyc = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((sel == 0) ? v0 : v1) begin
                atCyc = cyc;
                break;
            end
        end
    endtask

    task automatic applyReset();
        ceOn  = 0;
        CE    = 1'b0;
        DSin  = 1'b0;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        CE    = 1'b1;
        DSin  = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        checks++; if (d0 !== 8'd128) begin errors++; $display("[TB] FAIL reset_dout0 got %0d want 128", d0); end
        checks++; if (v0 !== 1'b0)   begin errors++; $display("[TB] FAIL reset_valid0 got %b want 0", v0); end
        checks++; if (s0 !== 1'b0)   begin errors++; $display("[TB] FAIL reset_sat0 got %b want 0", s0); end
        checks++; if (f0 !== 1'b0)   begin errors++; $display("[TB] FAIL reset_fbout0 got %b want 0", f0); end
        checks++; if (d1 !== 8'd128) begin errors++; $display("[TB] FAIL reset_dout1 got %0d want 128", d1); end
        applyReset();
    endtask

`ifndef SD_DECIM_SINC2_EN
    task automatic test_const_zero();
        applyReset();
        startPattern(0, 0);
        waitValid(1, 300, at);
        checks++; if (at !== 256)    begin errors++; $display("[TB] FAIL const0_first_valid got cyc %0d want 256", at); end
        checks++; if (d1 !== 8'd255) begin errors++; $display("[TB] FAIL const0_inv1_dout got %0d want 255", d1); end
        checks++; if (s1 !== 1'b1)   begin errors++; $display("[TB] FAIL const0_inv1_sat got %b want 1", s1); end
        checks++; if (f1 !== 1'b0)   begin errors++; $display("[TB] FAIL const0_fbout got %b want 0", f1); end
        checks++; if (v0 !== 1'b1)   begin errors++; $display("[TB] FAIL const0_inv0_valid got %b want 1", v0); end
        checks++; if (d0 !== 8'd0)   begin errors++; $display("[TB] FAIL const0_inv0_dout got %0d want 0", d0); end
        checks++; if (s0 !== 1'b0)   begin errors++; $display("[TB] FAIL const0_inv0_sat got %b want 0", s0); end
        step();
        checks++; if (v1 !== 1'b0)   begin errors++; $display("[TB] FAIL const0_valid_width got %b want 0", v1); end
        checks++; if (d1 !== 8'd255) begin errors++; $display("[TB] FAIL const0_dout_hold got %0d want 255", d1); end
        waitValid(1, 300, at);
        checks++; if (at !== 512)    begin errors++; $display("[TB] FAIL const0_period got cyc %0d want 512", at); end
    endtask

    task automatic test_toggle();
        applyReset();
        startPattern(2, 0);
        waitValid(0, 300, at);
        checks++; if (at !== 256)    begin errors++; $display("[TB] FAIL toggle_valid got cyc %0d want 256", at); end
        checks++; if (d0 !== 8'd128) begin errors++; $display("[TB] FAIL toggle_dout0 got %0d want 128", d0); end
        checks++; if (s0 !== 1'b0)   begin errors++; $display("[TB] FAIL toggle_sat0 got %b want 0", s0); end
        checks++; if (d1 !== 8'd128) begin errors++; $display("[TB] FAIL toggle_dout1 got %0d want 128", d1); end
    endtask

    task automatic test_quarter();
        applyReset();
        startPattern(3, 0);
        waitValid(0, 300, at);
        checks++; if (d0 !== 8'd64)  begin errors++; $display("[TB] FAIL quarter_dout0 got %0d want 64", d0); end
        checks++; if (d1 !== 8'd192) begin errors++; $display("[TB] FAIL quarter_dout1 got %0d want 192", d1); end
        applyReset();
        startPattern(4, 0);
        waitValid(0, 300, at);
        checks++; if (d0 !== 8'd192) begin errors++; $display("[TB] FAIL threeq_dout0 got %0d want 192", d0); end
        checks++; if (d1 !== 8'd64)  begin errors++; $display("[TB] FAIL threeq_dout1 got %0d want 64", d1); end
    endtask

    task automatic test_ce_gap();
        applyReset();
        startPattern(1, 1);
        waitValid(0, 1100, at);
        checks++; if (at !== 1021)   begin errors++; $display("[TB] FAIL cegap_first_valid got cyc %0d want 1021", at); end
        checks++; if (d0 !== 8'd255) begin errors++; $display("[TB] FAIL cegap_dout got %0d want 255", d0); end
        checks++; if (s0 !== 1'b1)   begin errors++; $display("[TB] FAIL cegap_sat got %b want 1", s0); end
        step();
        checks++; if (v0 !== 1'b0)   begin errors++; $display("[TB] FAIL cegap_valid_width got %b want 0", v0); end
        waitValid(0, 1100, at);
        checks++; if (at !== 2045)   begin errors++; $display("[TB] FAIL cegap_period got cyc %0d want 2045", at); end
    endtask

    task automatic test_reset_mid();
        applyReset();
        startPattern(1, 0);
        waitValid(0, 300, at);
        checks++; if (d0 !== 8'd255) begin errors++; $display("[TB] FAIL midrst_pre_dout got %0d want 255", d0); end
        repeat (100) step();
        RESET = 1'b1;
        #1;
        checks++; if (d0 !== 8'd128) begin errors++; $display("[TB] FAIL midrst_dout got %0d want 128", d0); end
        checks++; if (v0 !== 1'b0)   begin errors++; $display("[TB] FAIL midrst_valid got %b want 0", v0); end
        ceOn = 0;
        CE   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        startPattern(3, 0);
        checks++; if (v0 !== 1'b0)   begin errors++; $display("[TB] FAIL midrst_release_valid got %b want 0", v0); end
        waitValid(0, 300, at);
        checks++; if (at !== 256)    begin errors++; $display("[TB] FAIL midrst_next_valid got cyc %0d want 256", at); end
        checks++; if (d0 !== 8'd64)  begin errors++; $display("[TB] FAIL midrst_full_window got %0d want 64", d0); end
    endtask
`else
    task automatic test_sinc2_toggle();
        applyReset();
        startPattern(2, 0);
        waitValid(0, 600, at);
        checks++; if (at !== 512)    begin errors++; $display("[TB] FAIL sinc2_first_valid got cyc %0d want 512", at); end
        checks++; if (d0 !== 8'd128) begin errors++; $display("[TB] FAIL sinc2_toggle_w2 got %0d want 128", d0); end
        checks++; if (s0 !== 1'b0)   begin errors++; $display("[TB] FAIL sinc2_toggle_sat got %b want 0", s0); end
        waitValid(0, 300, at);
        checks++; if (at !== 768)    begin errors++; $display("[TB] FAIL sinc2_period got cyc %0d want 768", at); end
        checks++; if (d0 !== 8'd128) begin errors++; $display("[TB] FAIL sinc2_toggle_w3 got %0d want 128", d0); end
    endtask

    task automatic test_sinc2_step();
        applyReset();
        startPattern(5, 0);
        waitValid(0, 600, at);
        checks++; if (at !== 512)    begin errors++; $display("[TB] FAIL sinc2_step_w2_at got cyc %0d want 512", at); end
        checks++; if (d0 !== 8'd0)   begin errors++; $display("[TB] FAIL sinc2_step_w2 got %0d want 0", d0); end
        waitValid(0, 300, at);
        checks++; if (d0 !== 8'd127) begin errors++; $display("[TB] FAIL sinc2_step_w3 got %0d want 127", d0); end
        checks++; if (s0 !== 1'b0)   begin errors++; $display("[TB] FAIL sinc2_step_w3_sat got %b want 0", s0); end
        waitValid(0, 300, at);
        checks++; if (d0 !== 8'd255) begin errors++; $display("[TB] FAIL sinc2_step_w4 got %0d want 255", d0); end
        checks++; if (s0 !== 1'b1)   begin errors++; $display("[TB] FAIL sinc2_step_w4_sat got %b want 1", s0); end
    endtask
`endif

    initial begin
        test_reset();
`ifndef SD_DECIM_SINC2_EN
        test_const_zero();
        test_toggle();
        test_quarter();
        test_ce_gap();
        test_reset_mid();
`else
        test_sinc2_toggle();
        test_sinc2_step();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
